// File: rtl/serializador_p2s_pkg.sv
// Shared symbol constants, FSM encoding and symbol length for the serializer.
// Symbol length depends on PARITY_EN (9 bits with a trailing even-parity bit).
package serializador_p2s_pkg;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] PAD = 8'hF7;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] FTS = 8'h3C;
    localparam logic [7:0] IDL = 8'h7C;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

`ifdef PARITY_EN
    localparam int SYM_LEN = 9;
`else
    localparam int SYM_LEN = 8;
`endif

    localparam int CNT_W = 4;

    function automatic logic first_bit(
        input logic [7:0] b,
        input bit         msb
    );
        return msb ? b[7] : b[0];
    endfunction

endpackage

// File: rtl/serializador_p2s_contador_bits.sv
// Mod-L bit counter with asynchronous active-low clear.
// o_last flags the final bit slot of a symbol.
module contador_bits
    import serializador_p2s_pkg::*;
#(
    parameter int L = SYM_LEN
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(L - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last  = (r_count == LAST);
    assign o_count = r_count;
    assign o_last  = w_last;

    // count 0..L-1 and wrap
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serializador_p2s.sv
// Parallel-to-serial symbol serializer with IDLE insertion and sync preamble.
// Optional macro PARITY_EN appends an even-parity bit to every symbol.
module serializador_p2s
    import serializador_p2s_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE  = COM,
    parameter int         SYNC_BYTES = 4,
    parameter bit         MSB_FIRST  = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic [7:0] IN,
    input  logic       VALID,
    output logic       READY,
    output logic       SERIAL_OUT,
    output logic       FRAME
);

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(SYM_LEN - 1);
    localparam logic [3:0]       SYNC_LAST  = 4'(SYNC_BYTES - 1);
    localparam logic             IDLE_FIRST = first_bit(IDLE_BYTE, MSB_FIRST);
`ifdef PARITY_EN
    localparam logic [CNT_W-1:0] PAR_CNT    = CNT_W'(SYM_LEN - 2);
`endif

    state_t           r_state;
    state_t           w_state_nx;
    logic [3:0]       r_sync_cnt;
    logic [7:0]       r_shift;
    logic             r_out;
    logic             r_frame;
`ifdef PARITY_EN
    logic             r_par;
`endif

    logic [CNT_W-1:0] w_count;
    logic             w_last;
    logic             w_ready;
    logic             w_take;
    logic [7:0]       w_sym;
    logic [7:0]       w_shifted;

    contador_bits #(
        .L (SYM_LEN)
    ) u_contador_bits (
        .i_clk   (CLK),
        .i_rst_n (RESET_L),
        .o_count (w_count),
        .o_last  (w_last)
    );

    // READY and next state come from registers only, never from VALID
    always_comb begin
        w_state_nx = r_state;
        w_ready    = 1'b0;
        unique case (r_state)
            SYNC: begin
                w_ready = w_last && (r_sync_cnt == SYNC_LAST);
                if (w_ready) begin
                    w_state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                w_ready = w_last;
            end
        endcase
    end

    // IN is only selected on an accepted handshake, so X on IN stays off the line
    assign w_take    = w_ready && VALID;
    assign w_sym     = w_take ? IN : IDLE_BYTE;
    assign w_shifted = MSB_FIRST ? {r_shift[6:0], 1'b0}
                                 : {1'b0, r_shift[7:1]};

    assign READY      = w_ready;
    assign SERIAL_OUT = r_out;
    assign FRAME      = r_frame;

    // FSM state register
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // count IDLE symbols of the preamble
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_sync_cnt <= '0;
        end else if ((r_state == SYNC) && w_last) begin
            r_sync_cnt <= r_sync_cnt + 4'd1;
        end
    end

    // shift register, registered serial bit and frame marker
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_shift <= IDLE_BYTE;
            r_out   <= IDLE_FIRST;
            r_frame <= 1'b1;
`ifdef PARITY_EN
            r_par   <= ^IDLE_BYTE;
`endif
        end else begin
            r_frame <= (w_count == LAST_CNT);
            if (w_last) begin
                r_shift <= w_sym;
                r_out   <= first_bit(w_sym, MSB_FIRST);
`ifdef PARITY_EN
                r_par   <= ^w_sym;
`endif
            end else begin
                r_shift <= w_shifted;
`ifdef PARITY_EN
                if (w_count == PAR_CNT) begin
                    r_out <= r_par;
                end else begin
                    r_out <= first_bit(w_shifted, MSB_FIRST);
                end
`else
                r_out   <= first_bit(w_shifted, MSB_FIRST);
`endif
            end
        end
    end

endmodule
